// File: rtl/sdes_key_scheduler.sv
// sdes_key_scheduler
// Produces the round subkeys of an S-DES style key schedule from a 10-bit
// master key, one subkey per valid/ready transfer, in ascending (encrypt)
// or descending (decrypt) round order.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - request a new schedule (only honoured while idle)
//   key       - 10-bit master key, captured with start
//   decrypt   - 0: rounds 0..N-1, 1: rounds N-1..0; captured with start
//   idle      - block can accept start
//   sk_valid  - subkey/sk_index hold a valid round subkey
//   sk_ready  - consumer accepts the current subkey
//   subkey    - 8-bit round subkey (registered)
//   sk_index  - 0-based round number of subkey
//   done      - one-cycle pulse after the final transfer
module sdes_key_scheduler #(
    parameter int NUM_ROUNDS = 2,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       key,
    input  logic             decrypt,
    output logic             idle,
    output logic             sk_valid,
    input  logic             sk_ready,
    output logic [7:0]       subkey,
    output logic [IDX_W-1:0] sk_index,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Cumulative left rotation of the last round: 1 for round 0, otherwise
    // 1+2r folded into the 5-bit half.
    localparam int               DEC_ROT_INT = (NUM_ROUNDS == 1) ? 1 : ((1 + 2 * (NUM_ROUNDS - 1)) % 5);
    localparam logic [2:0]       DEC_ROT     = 3'(DEC_ROT_INT);

    state_t     state;
    logic [4:0] l_half;
    logic [4:0] r_half;
    logic       mode;

    logic [9:0] p10;
    logic [2:0] load_rot;
    logic [4:0] load_l;
    logic [4:0] load_r;
    logic [4:0] step_l;
    logic [4:0] step_r;
    logic       last_round;

    // Left rotation of a 5-bit half by 0..4 positions.
    function automatic logic [4:0] rotl5(input logic [4:0] x, input logic [2:0] n);
        logic [4:0] y;
        case (n)
            3'd1:    y = {x[3:0], x[4]};
            3'd2:    y = {x[2:0], x[4:3]};
            3'd3:    y = {x[1:0], x[4:2]};
            3'd4:    y = {x[0], x[4:1]};
            default: y = x;
        endcase
        return y;
    endfunction

    // P8 selection of the rotated halves.
    function automatic logic [7:0] p8(input logic [4:0] l, input logic [4:0] r);
        return {r[4], l[2], r[3], l[1], r[2], l[0], r[0], r[1]};
    endfunction

    assign idle     = (state == IDLE);
    assign sk_valid = (state == EMIT);
    assign done     = (state == DONE);

    // Load path: P10 of the key, rotated straight to the first round to be
    // emitted. Step path: two rounds differ by a rotation of 2, so the
    // decrypt direction rotates right 2 (left 3) on every step, including
    // round 1 -> round 0 where the cumulative amount goes from 3 to 1.
    always_comb begin
        p10        = {key[7], key[5], key[8], key[3], key[6],
                      key[0], key[9], key[1], key[2], key[4]};
        load_rot   = decrypt ? DEC_ROT : 3'd1;
        load_l     = rotl5(p10[9:5], load_rot);
        load_r     = rotl5(p10[4:0], load_rot);
        step_l     = rotl5(l_half, mode ? 3'd3 : 3'd2);
        step_r     = rotl5(r_half, mode ? 3'd3 : 3'd2);
        last_round = mode ? (sk_index == '0) : (sk_index == LAST_IDX);
    end

    // Schedule FSM. subkey is computed from the halves being loaded or
    // stepped so that it is already valid in the cycle sk_valid rises and
    // after every accepted transfer. Key and mode are only captured in IDLE,
    // so later changes on key/decrypt/start cannot disturb a running schedule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            l_half   <= '0;
            r_half   <= '0;
            mode     <= 1'b0;
            subkey   <= '0;
            sk_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        l_half   <= load_l;
                        r_half   <= load_r;
                        mode     <= decrypt;
                        subkey   <= p8(load_l, load_r);
                        sk_index <= decrypt ? LAST_IDX : '0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (sk_ready) begin
                        if (last_round) begin
                            state <= DONE;
                        end else begin
                            l_half   <= step_l;
                            r_half   <= step_r;
                            subkey   <= p8(step_l, step_r);
                            sk_index <= mode ? (sk_index - IDX_ONE) : (sk_index + IDX_ONE);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_key_scheduler.sv
// tb_sdes_key_scheduler
// Scoreboard bench: expected subkeys are queued when a schedule is started,
// and a monitor pops and compares on every valid/ready transfer. Two
// instances cover NUM_ROUNDS=2 and NUM_ROUNDS=3.
module tb_sdes_key_scheduler;

    typedef struct packed {
        logic [7:0] sk;
        logic [3:0] idx;
    } exp_t;

    localparam logic [9:0] KEY_A = 10'b1010000010;

    logic       clk = 1'b0;
    logic       rst;
    logic       start2;
    logic       start3;
    logic [9:0] key;
    logic       decrypt;
    logic       sk_ready;

    logic       idle2, sk_valid2, done2;
    logic [7:0] subkey2;
    logic [3:0] sk_index2;
    logic       idle3, sk_valid3, done3;
    logic [7:0] subkey3;
    logic [3:0] sk_index3;

    exp_t q2[$];
    exp_t q3[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done2Count  = 0;
    int   done3Count  = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    sdes_key_scheduler #(.NUM_ROUNDS(2), .IDX_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .key(key), .decrypt(decrypt),
        .idle(idle2), .sk_valid(sk_valid2), .sk_ready(sk_ready),
        .subkey(subkey2), .sk_index(sk_index2), .done(done2)
    );

    sdes_key_scheduler #(.NUM_ROUNDS(3), .IDX_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .key(key), .decrypt(decrypt),
        .idle(idle3), .sk_valid(sk_valid3), .sk_ready(sk_ready),
        .subkey(subkey3), .sk_index(sk_index3), .done(done3)
    );

    // Single comparison point: counts every check and reports mismatches.
    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endfunction

    // Monitor: every accepted subkey is checked against the queue head, and
    // a done pulse must only appear once all queued subkeys were consumed.
    always @(negedge clk) begin
        exp_t e2;
        exp_t e3;
        if (!rst && sk_valid2 && sk_ready) begin
            if (q2.size() == 0) begin
                checkOutput("n2_unexpected_transfer", 32'd1, 32'd0);
            end else begin
                e2 = q2.pop_front();
                checkOutput("n2_subkey", 32'(subkey2), 32'(e2.sk));
                checkOutput("n2_index", 32'(sk_index2), 32'(e2.idx));
            end
        end
        if (!rst && sk_valid3 && sk_ready) begin
            if (q3.size() == 0) begin
                checkOutput("n3_unexpected_transfer", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                checkOutput("n3_subkey", 32'(subkey3), 32'(e3.sk));
                checkOutput("n3_index", 32'(sk_index3), 32'(e3.idx));
            end
        end
        if (!rst && done2) begin
            done2Count++;
            checkOutput("n2_done_after_all", 32'(q2.size()), 32'd0);
        end
        if (!rst && done3) begin
            done3Count++;
            checkOutput("n3_done_after_all", 32'(q3.size()), 32'd0);
        end
    end

    task automatic pushExp(input int which, input logic [7:0] sk, input logic [3:0] idx);
        exp_t e;
        e.sk  = sk;
        e.idx = idx;
        if (which == 2) q2.push_back(e);
        else            q3.push_back(e);
    endtask

    // Pulses start for one cycle on an idle instance, checks the first
    // subkey is presented one cycle later, then scrambles key/decrypt.
    task automatic applyStimulus(input int which, input logic [9:0] k, input logic d);
        @(posedge clk); #1;
        key     = k;
        decrypt = d;
        if (which == 2) start2 = 1'b1;
        else            start3 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        start3 = 1'b0;
        checkOutput("latency1_valid", 32'(which == 2 ? sk_valid2 : sk_valid3), 32'd1);
        checkOutput("latency1_not_idle", 32'(which == 2 ? idle2 : idle3), 32'd0);
        key     = ~k;
        decrypt = ~d;
    endtask

    // Bounded wait for done; afterwards the pulse must be gone and idle set.
    task automatic waitDone(input int which, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 2) ? done2 : done3) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(which == 2 ? done2 : done3), 32'd0);
        checkOutput("idle_after_done", 32'(which == 2 ? idle2 : idle3), 32'd1);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneBefore;
        rst      = 1'b1;
        start2   = 1'b0;
        start3   = 1'b0;
        key      = '0;
        decrypt  = 1'b0;
        sk_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_idle", 32'(idle2), 32'd1);
        checkOutput("rst_valid", 32'(sk_valid2), 32'd0);
        checkOutput("rst_done", 32'(done2), 32'd0);
        checkOutput("rst_subkey", 32'(subkey2), 32'h00);
        checkOutput("rst_index", 32'(sk_index2), 32'd0);
        checkOutput("rst_idle3", 32'(idle3), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Encrypt and decrypt, two rounds
        pushExp(2, 8'hA4, 4'd0);
        pushExp(2, 8'h43, 4'd1);
        applyStimulus(2, KEY_A, 1'b0);
        waitDone(2, 10);

        pushExp(2, 8'h43, 4'd1);
        pushExp(2, 8'hA4, 4'd0);
        applyStimulus(2, KEY_A, 1'b1);
        waitDone(2, 10);

        // Three rounds, both directions
        pushExp(3, 8'hA4, 4'd0);
        pushExp(3, 8'h43, 4'd1);
        pushExp(3, 8'h28, 4'd2);
        applyStimulus(3, KEY_A, 1'b0);
        waitDone(3, 10);

        pushExp(3, 8'h28, 4'd2);
        pushExp(3, 8'h43, 4'd1);
        pushExp(3, 8'hA4, 4'd0);
        applyStimulus(3, KEY_A, 1'b1);
        waitDone(3, 10);

        // Back-pressure on the first subkey
        sk_ready = 1'b0;
        pushExp(2, 8'hA4, 4'd0);
        pushExp(2, 8'h43, 4'd1);
        applyStimulus(2, KEY_A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(sk_valid2), 32'd1);
            checkOutput("stall_subkey", 32'(subkey2), 32'hA4);
            checkOutput("stall_index", 32'(sk_index2), 32'd0);
            checkOutput("stall_no_done", 32'(done2), 32'd0);
        end
        @(posedge clk); #1;
        sk_ready = 1'b1;
        waitDone(2, 10);

        // start during EMIT must be ignored
        pushExp(2, 8'hA4, 4'd0);
        pushExp(2, 8'h43, 4'd1);
        applyStimulus(2, KEY_A, 1'b0);
        key    = 10'h3FF;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        waitDone(2, 10);

        pushExp(2, 8'h00, 4'd0);
        pushExp(2, 8'h00, 4'd1);
        applyStimulus(2, 10'h000, 1'b0);
        waitDone(2, 10);

        // Reset after the first transfer abandons the schedule
        doneBefore = done2Count;
        pushExp(2, 8'hA4, 4'd0);
        applyStimulus(2, KEY_A, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(sk_valid2), 32'd0);
        checkOutput("midrst_idle", 32'(idle2), 32'd1);
        checkOutput("midrst_done", 32'(done2), 32'd0);
        checkOutput("midrst_subkey", 32'(subkey2), 32'h00);
        checkOutput("midrst_index", 32'(sk_index2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_no_done", 32'(done2Count), 32'(doneBefore));
        checkOutput("midrst_queue_drained", 32'(q2.size()), 32'd0);

        pushExp(2, 8'hA4, 4'd0);
        pushExp(2, 8'h43, 4'd1);
        applyStimulus(2, KEY_A, 1'b0);
        waitDone(2, 10);

        // Totals
        checkOutput("n2_done_count", 32'(done2Count), 32'd6);
        checkOutput("n3_done_count", 32'(done3Count), 32'd2);
        checkOutput("n2_queue_empty", 32'(q2.size()), 32'd0);
        checkOutput("n3_queue_empty", 32'(q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
